// File: rtl/mmio_uart_tx.sv
// MMIO byte transmitter: DATA writes feed a queue, a start/8N/stop framer drives TXD from a flop.
// Define UART_TX_FIFO_EN for a 4-entry FIFO queue; otherwise a single holding register is used.
module mmio_uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD        = 115200
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        sel,
    input  logic        addr,
    input  logic        wstrb,
    input  logic [7:0]  wdata,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic        TXD
);
    // CLKS_PER_BIT must be at least 2.
    localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     rdata_q, rdata_d;

    logic       wr_req, rd_status, q_push, q_pop, q_empty, q_full, dropped, baud_end, busy;
    logic [7:0] q_head;

    assign wr_req    = sel & wstrb & ~addr;
    assign rd_status = sel & rstrb & addr;
    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign q_push    = wr_req & (~q_full | q_pop);
    assign dropped   = wr_req & q_full & ~q_pop;
    assign busy      = (state_q != StIdle);
    assign baud_end  = (baud_q == CntW'(ClksPerBit - 1));

`ifdef UART_TX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;

    assign q_empty = (count_q == 3'd0);
    assign q_full  = (count_q == 3'd4);
    assign q_head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d = mem_q;
        if (q_push) mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = wr_ptr_q + 2'(q_push);
        rd_ptr_d = rd_ptr_q + 2'(q_pop);
        count_d  = count_q + 3'(q_push) - 3'(q_pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;

    assign q_empty = ~hold_vld_q;
    assign q_full  = hold_vld_q;
    assign q_head  = hold_q;

    always_comb begin
        hold_d     = q_push ? wdata : hold_q;
        hold_vld_d = q_push ? 1'b1 : (q_pop ? 1'b0 : hold_vld_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        q_pop   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!q_empty) begin
                    q_pop   = 1'b1;
                    shift_d = q_head;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!q_empty) begin
                        q_pop   = 1'b1;
                        shift_d = q_head;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // TXD follows the registered state, so the line lags the FSM by one cycle.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (dropped)        ovf_d = 1'b1;
        else if (rd_status) ovf_d = 1'b0;
        rdata_d = rdata_q;
        if (sel & rstrb) begin
            rdata_d = addr ? {28'd0, ovf_q, q_empty, q_full, busy} : 32'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign TXD   = txd_q;
    assign rdata = rdata_q;

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division, SHALL be >= 2).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sel  input  1  bus select for this peripheral from SOC address decode.
REQ-006 SHALL have port addr  input  1  register select: 0 = DATA, 1 = STATUS (CPU word address bit 2).
REQ-007 SHALL have port wstrb  input  1  write strobe, one cycle per write.
REQ-008 SHALL have port wdata  input  8  byte to transmit (byte lane 0).
REQ-009 SHALL have port rstrb  input  1  read strobe, one cycle per read.
REQ-010 SHALL have port rdata  output  32  read data, registered.
REQ-011 SHALL have port TXD  output  1  serial line, idle high.

Function
REQ-012 SHALL enqueue wdata when sel & wstrb & addr==0 and the queue is not full.
REQ-013 SHALL drop a DATA write while full and set a sticky overflow flag.
REQ-014 SHALL, when full and a frame start pops the queue in the same cycle, accept the write (no overflow).
REQ-015 SHALL ignore writes to STATUS.
REQ-016 SHALL return STATUS on rdata one cycle after sel & rstrb & addr==1: bit0 busy (frame in progress), bit1 full, bit2 empty, bit3 overflow, bits31:4 zero.
REQ-017 SHALL clear overflow on a STATUS read, unless a dropped write occurs in the same cycle, in which case overflow stays set.
REQ-018 SHALL return 0 on rdata one cycle after a DATA read; rdata SHALL hold its value when no read is strobed.
REQ-019 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-020 IDLE: TXD=1; when queue non-empty, pop the head byte into a shift register and enter START on the next edge.
REQ-021 START: TXD=0 for CLKS_PER_BIT cycles.
REQ-022 DATA: 8 bits LSB first, each CLKS_PER_BIT cycles.
REQ-023 STOP: TXD=1 for CLKS_PER_BIT cycles; then IDLE, or START directly if queue non-empty (back-to-back frames with no idle gap).
REQ-024 SHALL drive TXD from a register (glitch-free); first start-bit cycle SHALL occur 2 cycles after the accepting write edge when idle and empty.
REQ-025 SHALL keep the baud counter width ceil(log2(CLKS_PER_BIT)) and the bit counter at 3 bits; no wrap beyond bit 7.

Reset
REQ-026 SHALL on RESET: FSM=IDLE, TXD=1, rdata=0, queue empty, overflow=0, counters=0.
REQ-027 SHALL abort a frame in progress on RESET; TXD SHALL be 1 from the cycle after the reset edge; queued bytes SHALL be lost.
REQ-028 SHALL give RESET priority over simultaneous write and read strobes.

Configuration
REQ-029 SHALL use macro UART_TX_FIFO_EN: defined -> queue is a 4-entry FIFO (2-bit pointers wrapping 3->0, occupancy count 0..4); undefined -> queue is a single holding register (full = holding register occupied).

Verification
REQ-030 SHALL bench with CLK_FREQ_HZ=1000, BAUD=100 (10 clocks/bit), both with and without UART_TX_FIFO_EN.
REQ-031 Write 0x55 while idle -> TXD: 10 cycles 0, then 1,0,1,0,1,0,1,0 (10 cycles each), 10 cycles 1; frame totals 100 cycles; STATUS busy=1 during, 0 after.
REQ-032 Write 0x41,0x42,0x43 back-to-back (FIFO build) -> three contiguous 100-cycle frames with no idle gap; STATUS empty=1 only after the third byte is popped.
REQ-033 Write 6 bytes in 6 consecutive cycles while idle (FIFO build) -> first byte popped, next 4 queued, 6th dropped; STATUS = 0x0B (busy, full, overflow); a second STATUS read returns 0x03.
REQ-034 Without UART_TX_FIFO_EN: write 0xA5, 0x5A, 0xFF in 3 consecutive cycles -> 0xA5 and 0x5A transmitted, 0xFF dropped, overflow=1.
REQ-035 Assert RESET in data bit 3 of frame 0x0F with 2 bytes queued -> TXD=1 from the next cycle, STATUS=0x04, no further frames.
